// File: rtl/traffic_ctrl_if.sv
// Bundle of run-control, request and light signals for the traffic sequencer.
// The master side (environment) drives enable and requests; the slave side
// (sequencer) drives the lamps, the state code and the phase count.
interface traffic_ctrl_if;
    logic       en;
    logic       side_req;
    logic       ped_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] state;
    logic [3:0] count;

    modport master (
        output en, side_req, ped_req,
        input  main_light, side_light, walk, state, count
    );

    modport slave (
        input  en, side_req, ped_req,
        output main_light, side_light, walk, state, count
    );
endinterface

// File: rtl/traffic_ctrl.sv
// Self-timed traffic-light sequencer: main road, side road and pedestrian
// crossing. A 4-bit down-counter times each phase; the Moore FSM advances
// when the counter expires (en=1 and count=0). Lamps are decoded from the
// state register only.
module traffic_ctrl #(
    parameter int T_GREEN_MAIN = 8,
    parameter int T_GREEN_SIDE = 5,
    parameter int T_YELLOW     = 2,
    parameter int T_ALLRED     = 1,
    parameter int T_WALK       = 6
) (
    input  logic           clock,
    input  logic           reset,
    traffic_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        MAIN_G  = 3'd0,
        MAIN_Y  = 3'd1,
        RED_A   = 3'd2,
        SIDE_G  = 3'd3,
        SIDE_Y  = 3'd4,
        RED_B   = 3'd5,
        WALK    = 3'd6,
        ILLEGAL = 3'd7
    } state_t;

    // Count reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] LD_GM = 4'(T_GREEN_MAIN - 1);
    localparam logic [3:0] LD_GS = 4'(T_GREEN_SIDE - 1);
    localparam logic [3:0] LD_Y  = 4'(T_YELLOW - 1);
    localparam logic [3:0] LD_AR = 4'(T_ALLRED - 1);
    localparam logic [3:0] LD_WK = 4'(T_WALK - 1);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    state_t     state_q;
    logic [3:0] count_q;
    logic       ped_pending_q;

    logic       svc;
    logic       walk_req;

    // The live ped_req counts as well as the latched one, so a press on the
    // deciding cycle itself is not missed.
    assign walk_req = ped_pending_q | bus.ped_req;
    assign svc      = bus.side_req | walk_req;

    // Phase sequencer: state, phase counter and pedestrian latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= MAIN_G;
            count_q       <= LD_GM;
            ped_pending_q <= 1'b0;
        end else begin
            // Latch button presses outside WALK regardless of en; a press
            // during WALK would only re-trigger the crossing just served.
            if (bus.ped_req && state_q != WALK)
                ped_pending_q <= 1'b1;

            if (state_q == ILLEGAL) begin
                // Recover through an all-red clearance before main green.
                state_q <= RED_B;
                count_q <= LD_AR;
            end else if (bus.en) begin
                if (count_q != 4'd0) begin
                    count_q <= count_q - 4'd1;
                end else begin
                    case (state_q)
                        MAIN_G: begin
                            // Without demand main green simply holds at 0.
                            if (svc) begin
                                state_q <= MAIN_Y;
                                count_q <= LD_Y;
                            end
                        end
                        MAIN_Y: begin
                            state_q <= RED_A;
                            count_q <= LD_AR;
                        end
                        RED_A: begin
                            // Pedestrians take priority; side traffic waits
                            // for the next pass through the cycle.
                            if (walk_req) begin
                                state_q       <= WALK;
                                count_q       <= LD_WK;
                                ped_pending_q <= 1'b0;
                            end else begin
                                state_q <= SIDE_G;
                                count_q <= LD_GS;
                            end
                        end
                        SIDE_G: begin
                            state_q <= SIDE_Y;
                            count_q <= LD_Y;
                        end
                        SIDE_Y: begin
                            state_q <= RED_B;
                            count_q <= LD_AR;
                        end
                        WALK: begin
                            state_q <= RED_B;
                            count_q <= LD_AR;
                        end
                        RED_B: begin
                            state_q <= MAIN_G;
                            count_q <= LD_GM;
                        end
                        default: begin
                            state_q <= RED_B;
                            count_q <= LD_AR;
                        end
                    endcase
                end
            end
        end
    end

    // Lamp decode from the state register; unknown codes fail safe to all-red.
    always_comb begin
        bus.main_light = L_RED;
        bus.side_light = L_RED;
        bus.walk       = 1'b0;
        case (state_q)
            MAIN_G: bus.main_light = L_GRN;
            MAIN_Y: bus.main_light = L_YEL;
            SIDE_G: bus.side_light = L_GRN;
            SIDE_Y: bus.side_light = L_YEL;
            WALK:   bus.walk       = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = state_q;
    assign bus.count = count_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Randomised and directed bench for traffic_ctrl. A phase/elapsed-time model
// built from tables of phase lengths and lamp patterns predicts every cycle.
module tb_traffic_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    traffic_ctrl_if bus();

    traffic_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference tables indexed by phase code.
    localparam int PH_LEN [7] = '{8, 2, 1, 5, 2, 1, 6};
    localparam int MAIN_L [7] = '{1, 2, 4, 4, 4, 4, 4};
    localparam int SIDE_L [7] = '{4, 4, 4, 1, 2, 4, 4};

    int m_ph;   // current phase
    int m_el;   // enabled cycles already spent in this phase
    bit m_pp;   // pedestrian waiting

    function automatic void model_reset();
        m_ph = 0;
        m_el = 0;
        m_pp = 0;
    endfunction

    // Advance the model by one clock given the inputs seen at that edge.
    function automatic void model_step(input bit e, input bit s, input bit p);
        int old_ph = m_ph;
        bit pp_old = m_pp;
        bit walked = 0;
        if (e) begin
            if (m_el + 1 < PH_LEN[m_ph]) begin
                m_el++;
            end else begin
                int nxt;
                case (m_ph)
                    0: nxt = (s | pp_old | p) ? 1 : 0;
                    1: nxt = 2;
                    2: nxt = (pp_old | p) ? 6 : 3;
                    3: nxt = 4;
                    4: nxt = 5;
                    6: nxt = 5;
                    default: nxt = 0;
                endcase
                if (!(m_ph == 0 && nxt == 0)) begin
                    m_ph   = nxt;
                    m_el   = 0;
                    walked = (nxt == 6);
                end
            end
        end
        if (p && old_ph != 6) m_pp = 1;
        if (walked) m_pp = 0;
    endfunction

    task automatic check_all();
        chk("state", 32'(bus.state), 32'(m_ph));
        chk("count", 32'(bus.count), 32'(PH_LEN[m_ph] - 1 - m_el));
        chk("main_light", 32'(bus.main_light), 32'(MAIN_L[m_ph]));
        chk("side_light", 32'(bus.side_light), 32'(SIDE_L[m_ph]));
        chk("walk", 32'(bus.walk), 32'(m_ph == 6));
        chk("safe_greens", 32'(bus.main_light[0] & bus.side_light[0]), 32'd0);
        chk("safe_walk", 32'(bus.walk & (bus.main_light[0] | bus.side_light[0])), 32'd0);
    endtask

    // One clock: inputs applied after a falling edge, outputs checked on the next.
    task automatic cyc(input bit e, input bit s, input bit p);
        bus.en       = e;
        bus.side_req = s;
        bus.ped_req  = p;
        @(posedge clock);
        model_step(e, s, p);
        @(negedge clock);
        check_all();
    endtask

    // Asynchronous reset between edges; called right after a falling edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'(PH_LEN[0] - 1));
        chk({tag, "_main"}, 32'(bus.main_light), 32'd1);
        chk({tag, "_side"}, 32'(bus.side_light), 32'd4);
        chk({tag, "_walk"}, 32'(bus.walk), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.ped_req  = 1'b0;
        bus.side_req = 1'b0;
        check_all();
    endtask

    initial begin
        int sg;
        bit saw_side;
        bit s_lvl;
        bus.en       = 1'b1;
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        model_reset();

        // Reset state, then idle: main green holds with count saturated at 0.
        @(negedge clock);
        reset = 1'b1;
        check_all();
        for (int i = 0; i < 40; i++) cyc(1, 0, 0);

        // Side demand held from reset: 19-cycle period.
        do_reset("rst_side");
        for (int t = 1; t <= 40; t++) begin
            cyc(1, 1, 0);
            if (t == 8)  chk("t8_main_y", 32'(bus.state), 32'd1);
            if (t == 11) chk("t11_side_g", 32'(bus.state), 32'd3);
            if (t == 19) chk("t19_main_g", 32'(bus.state), 32'd0);
            if (t == 27) chk("t27_main_y", 32'(bus.state), 32'd1);
            if (t == 38) chk("t38_main_g", 32'(bus.state), 32'd0);
        end

        // One-cycle pedestrian pulse from an idle main green.
        do_reset("rst_ped");
        saw_side = 0;
        for (int t = 1; t <= 45; t++) begin
            cyc(1, 0, t == 20);
            if (bus.state == 3'd3) saw_side = 1;
            if (t == 21) chk("ped_main_y", 32'(bus.state), 32'd1);
            if (t == 24) chk("ped_walk", 32'(bus.walk), 32'd1);
        end
        chk("ped_no_side_g", 32'(saw_side), 32'd0);

        // Both requests: walk first, side green on the next pass.
        do_reset("rst_both");
        for (int t = 1; t <= 45; t++) begin
            cyc(1, 1, t < 4);
            if (t == 11) chk("both_walk_first", 32'(bus.state), 32'd6);
            if (t == 29) chk("both_side_next", 32'(bus.state), 32'd3);
        end

        // Enable dropped for 3 cycles at count=2 inside side green.
        do_reset("rst_en");
        sg = 0;
        for (int i = 0; i < 40 && bus.state != 3'd3; i++) cyc(1, 1, 0);
        chk("en_reach_side_g", 32'(bus.state), 32'd3);
        sg = 1;
        while (bus.count != 4'd2 && sg < 10) begin cyc(1, 0, 0); sg++; end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            sg++;
            chk("en_frozen_count", 32'(bus.count), 32'd2);
            chk("en_frozen_side", 32'(bus.side_light), 32'd1);
        end
        while (bus.state == 3'd3 && sg < 20) begin cyc(1, 0, 0); if (bus.state == 3'd3) sg++; end
        chk("en_side_g_wall_len", 32'(sg), 32'd8);

        // Reset during WALK.
        do_reset("rst_pre_walk");
        for (int i = 0; i < 40 && m_ph != 6; i++) cyc(1, 0, i == 0);
        chk("reach_walk", 32'(bus.walk), 32'd1);
        cyc(1, 0, 0);
        do_reset("rst_mid_walk");
        for (int i = 0; i < 15; i++) cyc(1, 0, 0);

        // Reset discards a pedestrian latched during main green.
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        do_reset("rst_pend");
        for (int i = 0; i < 20; i++) cyc(1, 0, 0);
        chk("pend_cleared", 32'(bus.state), 32'd0);

        // Random traffic with occasional asynchronous resets.
        s_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) s_lvl = ~s_lvl;
            if ($urandom_range(0, 399) == 0) do_reset("rst_rand");
            else cyc($urandom_range(0, 99) < 85, s_lvl, $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case something upstream stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
